// File: rtl/miner_tx_sched_pkg.sv
// miner_tx_sched_pkg: frame constants, scheduler state encoding and the frame byte builder.
package miner_tx_sched_pkg;
  localparam logic [7:0] HDR_DEF = 8'hA5;
  localparam logic [2:0] FRAME_LEN = 3'd7;
  localparam logic [2:0] ACK_LEN = 3'd1;
  localparam int IDX_W = 4;
  typedef enum logic [2:0] {IDLE, GRANT, STROBE, WAIT_BUSY, WAIT_DONE, NEXT} state_t;
  // Ack frames carry their single byte in the low nonce byte.
  function automatic logic [7:0] frame_byte(input logic [7:0] hdr, input logic ack, input logic [2:0] n,
                                            input logic [IDX_W-1:0] idx, input logic [31:0] nc);
    logic [7:0] ix;
    logic [7:0] b;
    ix = {{(8-IDX_W){1'b0}}, idx};
    case (n)
      3'd0: b = hdr;
      3'd1: b = ix;
      3'd2: b = nc[7:0];
      3'd3: b = nc[15:8];
      3'd4: b = nc[23:16];
      3'd5: b = nc[31:24];
      default: b = ix ^ nc[7:0] ^ nc[15:8] ^ nc[23:16] ^ nc[31:24];
    endcase
    return ack ? nc[7:0] : b;
  endfunction
endpackage

// File: rtl/miner_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin pick, searching upward from last_grant+1 with wrap.
module rr_pick import miner_tx_sched_pkg::*; #(
  parameter int CORES = 1
) (
  input  logic [CORES-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] index
);
  logic [IDX_W-1:0] w_c;
  // Walk the distance downward so the nearest requester after last_grant wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    w_c = '0;
    for (int k = CORES; k >= 1; k--) begin
      w_c = IDX_W'((32'(last_grant) + 32'(k)) % 32'(CORES));
      if (|(req & (CORES'(1) << w_c))) begin
        valid = 1'b1;
        index = w_c;
      end
    end
  end
endmodule

// File: rtl/miner_tx_sched.sv
// miner_tx_sched: serialises host acks and round-robin hash-core results into UART byte frames.
module miner_tx_sched import miner_tx_sched_pkg::*; #(
  parameter int         CORES = 1,
  parameter logic [7:0] HDR   = HDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CORES-1:0]      req,
  input  logic [32*CORES-1:0]   nonce,
  output logic [CORES-1:0]      gnt,
  input  logic                  ack_req,
  input  logic [7:0]            ack_byte,
  output logic                  ack_done,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  input  logic                  is_transmitting,
  output logic                  busy
);
  state_t           r_state;
  logic             r_ack;
  logic [2:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last;
  logic [31:0]      r_nonce;
  logic [CORES-1:0] r_gnt;
  logic             r_ack_done;
  logic             r_tx;
  logic             r_busy;
  logic [7:0]       r_byte;
  logic             w_valid;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_nonce;
  logic             w_last;

  rr_pick #(.CORES(CORES)) u_pick (.req(req), .last_grant(r_last), .valid(w_valid), .index(w_idx));

  assign w_nonce  = 32'(nonce >> (32 * w_idx));
  assign w_last   = r_cnt == ((r_ack ? ACK_LEN : FRAME_LEN) - 3'd1);
  assign gnt      = r_gnt;
  assign ack_done = r_ack_done;
  assign transmit = r_tx;
  assign tx_byte  = r_byte;
  assign busy     = r_busy;

  // Selection is captured on the IDLE exit edge so gnt is visible during GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_last     <= IDX_W'(CORES - 1);
      r_nonce    <= '0;
      r_gnt      <= '0;
      r_ack_done <= 1'b0;
      r_tx       <= 1'b0;
      r_busy     <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_gnt      <= '0;
      r_ack_done <= 1'b0;
      r_tx       <= 1'b0;
      case (r_state)
        IDLE: if (ack_req) begin
          r_ack   <= 1'b1;
          r_nonce <= {24'd0, ack_byte};
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_state <= GRANT;
        end else if (w_valid) begin
          r_ack   <= 1'b0;
          r_nonce <= w_nonce;
          r_idx   <= w_idx;
          r_last  <= w_idx;
          r_gnt   <= CORES'(1) << w_idx;
          r_busy  <= 1'b1;
          r_state <= GRANT;
        end
        GRANT: begin
          r_cnt   <= '0;
          r_byte  <= frame_byte(HDR, r_ack, 3'd0, r_idx, r_nonce);
          r_tx    <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: r_state <= WAIT_BUSY;
        WAIT_BUSY: if (is_transmitting) r_state <= WAIT_DONE;
        WAIT_DONE: if (!is_transmitting) begin
          r_ack_done <= r_ack & w_last;
          r_state    <= NEXT;
        end
        NEXT: if (w_last) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_cnt   <= r_cnt + 3'd1;
          r_byte  <= frame_byte(HDR, r_ack, r_cnt + 3'd1, r_idx, r_nonce);
          r_tx    <= 1'b1;
          r_state <= STROBE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
